// File: rtl/seg7_bcd_display.sv
// rtl/seg7_bcd_display.sv - sequential double-dabble binary-to-7-segment display driver
// Optional raw-hex display mode guarded by SEG7_HEX_MODE_EN.
module seg7_bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  signed_mode,
`ifdef SEG7_HEX_MODE_EN
    input  logic                  hex_mode,
`endif
    output logic                  busy,
    output logic                  valid,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    localparam logic [6:0] MINUS = 7'b1111110;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mag;
    logic [BW-1:0]      bcd;
    logic [CW-1:0]      cnt;
    logic               carry;
    logic               neg;

    logic               neg_in;
    logic [BW-1:0]      adj;
    logic [BW-1:0]      bcd_nxt;
    logic               carry_nxt;
    logic [BW-1:0]      src_dig;
    logic               src_over;
    logic               src_neg;
    logic [7*DIGITS-1:0] hex_c;
    logic               ovf_c;
    int                 msd;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0001100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    assign neg_in = signed_mode & value[WIDTH-1];
    assign busy   = (state != S_IDLE);

    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
        end
    end

    assign bcd_nxt   = {adj[BW-2:0], mag[WIDTH-1]};
    assign carry_nxt = carry | adj[BW-1];

`ifdef SEG7_HEX_MODE_EN
    logic [WIDTH+BW-1:0] ext;
    assign ext = {{BW{1'b0}}, value};
`endif

    // Display source: the BCD state after the final shift, or raw nibbles in hex mode.
    always_comb begin
        src_dig  = bcd_nxt;
        src_over = carry_nxt;
        src_neg  = neg;
`ifdef SEG7_HEX_MODE_EN
        if (state == S_IDLE) begin
            src_dig  = ext[BW-1:0];
            src_over = |(ext >> BW);
            src_neg  = 1'b0;
        end
`endif
    end

    always_comb begin
        msd   = 0;
        hex_c = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (src_dig[4*k +: 4] != 4'd0) msd = k;
        end
        ovf_c = src_over | (src_neg && (msd == DIGITS - 1));
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf_c)
                hex_c[7*k +: 7] = MINUS;
            else if (k <= msd)
                hex_c[7*k +: 7] = glyph(src_dig[4*k +: 4]);
            else if (src_neg && (k == msd + 1))
                hex_c[7*k +: 7] = MINUS;
            else
                hex_c[7*k +: 7] = BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            mag   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            neg   <= 1'b0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            hex   <= '1;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        neg   <= neg_in;
                        mag   <= neg_in ? (~value + WIDTH'(1)) : value;
                        bcd   <= '0;
                        cnt   <= CW'(WIDTH);
                        carry <= 1'b0;
                        state <= S_CONV;
`ifdef SEG7_HEX_MODE_EN
                        if (hex_mode) begin
                            hex   <= hex_c;
                            ovf   <= ovf_c;
                            valid <= 1'b1;
                            state <= S_SHOW;
                        end
`endif
                    end
                end
                S_CONV: begin
                    bcd   <= bcd_nxt;
                    mag   <= {mag[WIDTH-2:0], 1'b0};
                    carry <= carry_nxt;
                    cnt   <= cnt - CW'(1);
                    // Publish on the last shift so hex is fresh throughout SHOW.
                    if (cnt == CW'(1)) begin
                        hex   <= hex_c;
                        ovf   <= ovf_c;
                        valid <= 1'b1;
                        state <= S_SHOW;
                    end
                end
                S_SHOW:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// tb/tb_seg7_bcd_display.sv - scoreboard bench for seg7_bcd_display against a decimal reference model
module tb_seg7_bcd_display;
    localparam int W = 8;
    localparam int D = 3;
    localparam logic [6:0] MINUS = 7'b1111110;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0001100};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic signed_mode = 1'b0;
    logic [W-1:0] value = '0;
    logic busy, valid, ovf;
    logic [7*D-1:0] hex;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nb;

    typedef struct {
        logic [7*D-1:0] hex;
        logic           ovf;
        int             at;
    } exp_t;
    exp_t sbq[$];
    exp_t got;

    seg7_bcd_display #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .signed_mode(signed_mode),
        .busy(busy), .valid(valid), .ovf(ovf), .hex(hex)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Decimal reference: signed interpretation, magnitude digits, field layout.
    function automatic void model(input logic [W-1:0] v, input logic sm,
                                  output logic [7*D-1:0] h, output logic o);
        int sv, m, nd, p, pk, lim;
        logic ng;
        sv = int'(v);
        if (sm && v[W-1]) sv = sv - (1 << W);
        ng = (sv < 0);
        m  = ng ? -sv : sv;
        nd = 1;
        p  = 10;
        while (m >= p) begin
            nd++;
            p = p * 10;
        end
        lim = 1;
        for (int i = 0; i < D; i++) lim = lim * 10;
        o  = (m >= lim) || (ng && nd >= D);
        pk = 1;
        for (int k = 0; k < D; k++) begin
            if (o)                   h[7*k +: 7] = MINUS;
            else if (k < nd)         h[7*k +: 7] = GLYPH[(m / pk) % 10];
            else if (ng && k == nd)  h[7*k +: 7] = MINUS;
            else                     h[7*k +: 7] = BLANK;
            pk = pk * 10;
        end
    endfunction

    // Called at #1 after an edge with the DUT idle; returns the same way.
    task automatic issue(input logic [W-1:0] v, input logic sm, input int glitch, output int nbusy);
        exp_t e;
        load = 1'b1;
        value = v;
        signed_mode = sm;
        @(posedge clk); #1;
        load = 1'b0;
        model(v, sm, e.hex, e.ovf);
        e.at = cyc + W;
        sbq.push_back(e);
        value = W'($urandom);
        signed_mode = 1'($urandom);
        nbusy = 0;
        while (busy && nbusy < 100) begin
            nbusy++;
            if (nbusy == glitch) begin
                load = 1'b1;
                value = W'(1);
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 32'(valid), 32'(0));
                end else begin
                    got = sbq.pop_front();
                    chk("hex", 32'(hex), 32'(got.hex));
                    chk("ovf", 32'(ovf), 32'(got.ovf));
                    chk("latency", 32'(cyc), 32'(got.at));
                end
            end
        end
    end

    initial begin
        #12;
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_valid", 32'(valid), 32'(0));
        chk("reset_ovf", 32'(ovf), 32'(0));
        chk("reset_hex", 32'(hex), 32'(21'h1FFFFF));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'd255, 1'b0, -1, nb);
        chk("busy_cycles", 32'(nb), 32'(W + 1));
        issue(8'hF6, 1'b1, -1, nb);
        chk("f6_hex_literal", 32'(hex), 32'({7'b1111110, 7'b1001111, 7'b0000001}));
        issue(8'h07, 1'b0, -1, nb);
        chk("07_hex_literal", 32'(hex), 32'({BLANK, BLANK, 7'b0001111}));
        issue(8'h9D, 1'b1, 3, nb);
        chk("glitch_busy_cycles", 32'(nb), 32'(W + 1));
        issue(8'h9C, 1'b1, -1, nb);
        issue(8'h80, 1'b1, -1, nb);
        chk("m128_ovf_literal", 32'(ovf), 32'(1));

        // Reset in the middle of a conversion: outputs return to reset values, no result.
        load = 1'b1;
        value = 8'd200;
        signed_mode = 1'b0;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_hex", 32'(hex), 32'(21'h1FFFFF));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_ovf", 32'(ovf), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (W + 3) @(posedge clk);
        #1;
        issue(8'd0, 1'b0, -1, nb);
        chk("zero_hex_literal", 32'(hex), 32'({BLANK, BLANK, 7'b0000001}));

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), 1'($urandom), -1, nb);
            if (($urandom % 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(sbq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
